ifetch_queue: RTL and testbench

- Instruction-fetch front end: owns the fetch PC and issues sequential word requests to instruction memory.
- Buffers in-order responses in a small FIFO and presents {instruction, pc, fault} to the decode stage over a valid/ready handshake.
- Handles control-flow redirects from execute by flushing the FIFO and discarding responses that are still in flight.
- Sits between instruction memory and the decode stage.

---
 rtl/ifetch_queue.sv | 134 +++++++++++++
 tb/tb_ifetch_queue.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: sequential PC generation, credit-limited requests,
// in-order response FIFO toward decode, and redirect flush with in-flight drop.
module ifetch_queue #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            imem_rsp_err,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instruction,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_fault
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0]     data;
    logic [XLEN-1:0] pc;
    logic            fault;
  } entry_t;

  entry_t          r_mem [DEPTH];
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   r_inflight;
  logic [CW-1:0]   r_drop;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_resp_pc;
  logic            r_halted;

  logic            w_credit_ok;
  logic            w_req_fire;
  logic            w_drop_rsp;
  logic            w_push;
  logic            w_pop;
  logic [CW-1:0]   w_inflight_next;
  logic [CW-1:0]   w_count_next;
  logic [XLEN-1:0] w_redirect_aligned;
  entry_t          w_push_entry;
  entry_t          w_head;
  logic            w_unused_bits;

  // Outstanding requests count against FIFO space so a returning response always has a slot.
  assign w_credit_ok    = ({1'b0, r_count} + {1'b0, r_inflight}) < (CW+1)'(DEPTH);
  assign imem_req_valid = rst && !redirect_valid && !r_halted && w_credit_ok;
  assign imem_req_addr  = r_fetch_pc;

  assign w_req_fire         = imem_req_valid && imem_req_ready;
  assign w_drop_rsp         = imem_rsp_valid && (r_drop != '0);
  assign w_push             = imem_rsp_valid && (r_drop == '0) && !redirect_valid;
  assign w_pop              = instr_valid && instr_ready && !redirect_valid;
  assign w_inflight_next    = r_inflight + CW'(w_req_fire) - CW'(imem_rsp_valid);
  assign w_count_next       = r_count + CW'(w_push) - CW'(w_pop);
  assign w_redirect_aligned = {redirect_pc[XLEN-1:2], 2'b00};
  assign w_unused_bits      = &{1'b0, redirect_pc[1:0]};

  assign w_push_entry.data  = imem_rsp_err ? 32'h0000_0013 : imem_rsp_data;
  assign w_push_entry.pc    = r_resp_pc;
  assign w_push_entry.fault = imem_rsp_err;

  assign w_head      = r_mem[r_rd_ptr];
  assign instr_valid = (r_count != '0);
  assign instruction = instr_valid ? w_head.data  : 32'h0000_0000;
  assign instr_pc    = instr_valid ? w_head.pc    : '0;
  assign instr_fault = instr_valid ? w_head.fault : 1'b0;

  // Control state: PCs, credits, drop counter, halt flag and FIFO pointers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_inflight <= '0;
      r_drop     <= '0;
      r_halted   <= 1'b0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else if (redirect_valid) begin
      // Flush beats pop; everything still outstanding after this cycle is stale.
      r_fetch_pc <= w_redirect_aligned;
      r_resp_pc  <= w_redirect_aligned;
      r_inflight <= w_inflight_next;
      r_drop     <= w_inflight_next;
      r_halted   <= 1'b0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_inflight <= w_inflight_next;
      r_count    <= w_count_next;
      if (w_req_fire) begin
        r_fetch_pc <= r_fetch_pc + XLEN'(4);
      end
      if (w_drop_rsp) begin
        r_drop <= r_drop - CW'(1);
      end
      if (w_push) begin
        r_wr_ptr  <= r_wr_ptr + AW'(1);
        r_resp_pc <= r_resp_pc + XLEN'(4);
        if (imem_rsp_err) begin
          r_halted <= 1'b1;
        end
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
    end
  end

  // FIFO storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_entry;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench: memory model with configurable latency, scoreboard of expected
// decode entries checked by an independent monitor on every pop.
module tb_ifetch_queue;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        instr_fault;

  ifetch_queue #(.XLEN(32), .RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instruction(instruction),
    .instr_pc(instr_pc), .instr_fault(instr_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [31:0] pc;
    logic        f;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    int          t;
  } pend_t;

  exp_t        exp_q[$];
  pend_t       pend[$];
  logic [31:0] req_log[$];
  int          req_cyc[$];
  int          pop_cyc[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          n_pop = 0;
  int          mcyc = 0;
  int          lat = 1;
  int          first_valid_cyc = -1;
  logic        err_en = 1'b0;
  logic [31:0] err_addr = 32'h0000_0008;

  task automatic chk(input string name, input logic [64:0] got, input logic [64:0] expv);
    n_chk++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, expv);
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [31:0] pc, input logic f);
    exp_t e;
    e.d = d; e.pc = pc; e.f = f;
    exp_q.push_back(e);
  endtask

  // Memory model: in-order, fixed latency, data = 0xAB000000 | address.
  initial begin
    pend_t p;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0000_0000;
    imem_rsp_err   = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      mcyc++;
      imem_rsp_valid = 1'b0;
      imem_rsp_err   = 1'b0;
      if (!rst) begin
        pend.delete();
      end else begin
        if (pend.size() > 0 && mcyc >= pend[0].t + lat) begin
          p = pend.pop_front();
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = 32'hAB00_0000 | p.a;
          imem_rsp_err   = err_en && (p.a == err_addr);
        end
        if (imem_req_valid && imem_req_ready) begin
          p.a = imem_req_addr;
          p.t = mcyc;
          pend.push_back(p);
          req_log.push_back(imem_req_addr);
          req_cyc.push_back(mcyc);
        end
      end
    end
  end

  // Monitor: every accepted decode entry is compared with the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        if (instr_valid && first_valid_cyc < 0) first_valid_cyc = mcyc;
        if (instr_valid && instr_ready && !redirect_valid) begin
          n_pop++;
          pop_cyc.push_back(mcyc);
          if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_pop: got pc %h, expected no entry", instr_pc);
          end else begin
            e = exp_q.pop_front();
            chk("pop_entry", 65'({instruction, instr_pc, instr_fault}), 65'(e));
          end
        end
      end
    end
  end

  task automatic do_reset(input int l);
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    err_en         = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("sb_drained", 65'(exp_q.size()), 65'(0));
    exp_q.delete(); req_log.delete(); req_cyc.delete(); pop_cyc.delete();
    n_pop = 0;
    first_valid_cyc = -1;
    lat = l;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_deliv(input int target, input int budget);
    int k;
    k = 0;
    while (n_pop < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (n_pop < target) begin
      n_chk++;
      $display("FAIL deliver_timeout: got %0d pops, expected %0d", n_pop, target);
    end
  endtask

  initial begin
    int seen;
    rst = 1'b1; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b1;
    #1 rst = 1'b0;
    #2;
    chk("rst_req_valid", 65'(imem_req_valid), 65'(0));
    chk("rst_instr_valid", 65'(instr_valid), 65'(0));
    chk("rst_outputs", 65'({instruction, instr_pc, instr_fault}), 65'(0));

    // 1: streaming at one per cycle
    do_reset(1);
    instr_ready = 1'b1;
    for (int i = 0; i < 8; i++) push_exp(32'hAB00_0000 | 32'(4*i), 32'(4*i), 1'b0);
    wait_deliv(8, 40);
    instr_ready = 1'b0;
    if (req_cyc.size() > 0)
      chk("t1_first_valid_latency", 65'(first_valid_cyc - req_cyc[0]), 65'(2));
    if (pop_cyc.size() >= 8)
      chk("t1_steady_rate", 65'(pop_cyc[7] - pop_cyc[0]), 65'(7));
    if (req_log.size() >= 3)
      chk("t1_req_addrs", 65'({req_log[0], req_log[1], req_log[2]}), 65'({32'h0, 32'h4, 32'h8}));

    // 2: back-pressure fills FIFO, credits stop requests
    do_reset(1);
    repeat (10) @(negedge clk);
    chk("t2_req_count", 65'(req_log.size()), 65'(4));
    chk("t2_req_stopped", 65'(imem_req_valid), 65'(0));
    for (int i = 0; i < 6; i++) push_exp(32'hAB00_0000 | 32'(4*i), 32'(4*i), 1'b0);
    instr_ready = 1'b1;
    wait_deliv(6, 40);
    instr_ready = 1'b0;
    if (req_log.size() > 4) chk("t2_resume_addr", 65'(req_log[4]), 65'(32'h10));

    // 3: redirect with three requests outstanding
    do_reset(5);
    instr_ready = 1'b1;
    push_exp(32'hAB00_0100, 32'h100, 1'b0);
    push_exp(32'hAB00_0104, 32'h104, 1'b0);
    repeat (3) @(negedge clk);
    imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    #1 chk("t3_no_req_on_redirect", 65'(imem_req_valid), 65'(0));
    @(negedge clk);
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      #1 if (instr_valid) seen++;
      @(negedge clk);
    end
    chk("t3_empty_while_dropping", 65'(seen), 65'(0));
    wait_deliv(2, 40);
    instr_ready = 1'b0;
    if (req_log.size() > 3) chk("t3_target_addr", 65'(req_log[3]), 65'(32'h100));

    // 4: redirect coincides with an arriving response and a ready decode
    do_reset(1);
    instr_ready = 1'b1;
    push_exp(32'hAB00_0000, 32'h0, 1'b0);
    push_exp(32'hAB00_0200, 32'h200, 1'b0);
    push_exp(32'hAB00_0204, 32'h204, 1'b0);
    repeat (3) @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    #1;
    chk("t4_no_req_on_redirect", 65'(imem_req_valid), 65'(0));
    chk("t4_head_before_flush", 65'({instr_valid, instr_pc}), 65'({1'b1, 32'h4}));
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_deliv(3, 40);
    instr_ready = 1'b0;
    if (req_log.size() > 3) chk("t4_next_req_addr", 65'(req_log[3]), 65'(32'h200));

    // 5: access fault halts fetch until a redirect
    do_reset(1);
    err_en = 1'b1; err_addr = 32'h8;
    instr_ready = 1'b1;
    push_exp(32'hAB00_0000, 32'h0, 1'b0);
    push_exp(32'hAB00_0004, 32'h4, 1'b0);
    push_exp(32'h0000_0013, 32'h8, 1'b1);
    push_exp(32'hAB00_000C, 32'hC, 1'b0);
    repeat (10) @(negedge clk);
    chk("t5_req_count_halted", 65'(req_log.size()), 65'(4));
    chk("t5_req_valid_halted", 65'(imem_req_valid), 65'(0));
    chk("t5_drained", 65'(n_pop), 65'(4));
    err_en = 1'b0;
    push_exp(32'hAB00_0040, 32'h40, 1'b0);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_deliv(5, 30);
    instr_ready = 1'b0;
    if (req_log.size() > 4) chk("t5_resume_addr", 65'(req_log[4]), 65'(32'h40));

    // 6: asynchronous reset mid-operation
    do_reset(3);
    repeat (5) @(negedge clk);
    chk("t6_pre_head", 65'({instr_valid, instruction}), 65'({1'b1, 32'hAB00_0000}));
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("t6_async_req_valid", 65'(imem_req_valid), 65'(0));
    chk("t6_async_outputs", 65'({instr_valid, instruction, instr_pc, instr_fault}), 65'(0));
    @(negedge clk);
    @(negedge clk);
    req_log.delete(); req_cyc.delete(); pop_cyc.delete();
    n_pop = 0; lat = 1;
    push_exp(32'hAB00_0000, 32'h0, 1'b0);
    push_exp(32'hAB00_0004, 32'h4, 1'b0);
    instr_ready = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    if (req_log.size() > 0) chk("t6_first_req_addr", 65'(req_log[0]), 65'(32'h0));
    else chk("t6_first_req_count", 65'(req_log.size()), 65'(1));
    wait_deliv(2, 30);
    instr_ready = 1'b0;
    @(negedge clk);
    chk("final_sb_drained", 65'(exp_q.size()), 65'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
